hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Pipeline hazard controller for the 5-stage MIPS core. It drives StallF/StallD for the IF/ID registers and FlushE for the ID/EX register, and selects the forwarding muxes in ID and EX. It also sequences the multi-cycle multiply/divide unit through a small FSM with a latency counter, and keeps a saturating stall-cycle counter for performance debug.

Parameters:
MUL_LAT, 4, EX-occupancy cycles of a MULT/MULTU (must be >=1)
DIV_LAT, 32, EX-occupancy cycles of a DIV/DIVU (must be >=1)
CNT_W, 6, latency counter width (must hold max(MUL_LAT,DIV_LAT)-1)

Ports:
clk  in  1  pipeline clock; all state updates on posedge
rst_n  in  1  synchronous active-low reset
Rs_D, Rt_D  in  5 each  source registers of the instruction in ID
Rs_E, Rt_E  in  5 each  source registers of the instruction in EX
WriteReg_E, WriteReg_M, WriteReg_W  in  5 each  destination registers in EX/MEM/WB
RegWrite_E, RegWrite_M, RegWrite_W  in  1 each  register-write enables per stage
MemtoReg_E, MemtoReg_M  in  1 each  load in EX / load in MEM
Branch_D  in  1  branch resolved in ID
MulDivStart_E  in  1  MULT/DIV in EX this cycle
MulDivIsDiv_E  in  1  1=divide, 0=multiply (valid with MulDivStart_E)
MulDivUse_D  in  1  instruction in ID is MULT/DIV/MFHI/MFLO
StallF, StallD  out  1 each  hold PC and IF/ID register
FlushE  out  1  clear ID/EX register
ForwardAE, ForwardBE  out  2 each  EX operand select: 00 regfile, 01 WB result, 10 MEM ALU result
ForwardAD, ForwardBD  out  1 each  ID branch-compare operand from MEM ALU result
MulDivBusy  out  1  multiplier/divider occupied
MulDivDone  out  1  one-cycle pulse: HI/LO valid
StallCount  out  32  saturating count of cycles with StallD=1

Behaviour:
- Register 0 never matches for forwarding or stall checks.
- Forwarding (combinational): ForwardAE=10 if RegWrite_M & WriteReg_M==Rs_E; else 01 if RegWrite_W & WriteReg_W==Rs_E; else 00. MEM wins when both match. ForwardBE is the same using Rt_E. ForwardAD/BD=RegWrite_M & WriteReg_M==Rs_D/Rt_D.
- lwstall = MemtoReg_E & (Rt_E==Rs_D | Rt_E==Rt_D).
- brstall = Branch_D & ((RegWrite_E & WriteReg_E in {Rs_D,Rt_D}) | (MemtoReg_M & WriteReg_M in {Rs_D,Rt_D})).
- mdstall = MulDivUse_D & (state==BUSY | MulDivStart_E).
- StallF = StallD = FlushE = lwstall|brstall|mdstall.
- FSM states:
  - IDLE: on MulDivStart_E, load cnt=(MulDivIsDiv_E?DIV_LAT:MUL_LAT)-1 and go to BUSY.
  - BUSY: when cnt==0, go to DONE; otherwise decrement cnt.
  - DONE: return to IDLE, or go directly to BUSY (reloading cnt) if MulDivStart_E.
- MulDivBusy=(state==BUSY). MulDivDone=(state==DONE).
- MulDivStart_E seen in BUSY is ignored. It cannot legally occur because mdstall holds ID.
- StallCount increments on each cycle with StallD=1 and saturates at 32'hFFFF_FFFF.
- Reset (rst_n low at posedge, including mid-operation): state=IDLE, cnt=0, StallCount=0. While rst_n is low, outputs are forced: FlushE=1, StallF=StallD=0, Forward*=0, MulDivBusy=MulDivDone=0.

Decomposition:
- Shared package mips_pkg: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10; the FSM state encoding (IDLE, BUSY, DONE).
- One sub-module, muldiv_seq: FSM, cnt, MulDivBusy/Done.
- Stall/forward logic and StallCount stay in the top module.

Test Plan:
1. lw $8 in EX (MemtoReg_E=1, Rt_E=8); add in ID with Rs_D=8 -> StallF=StallD=FlushE=1 for 1 cycle; next cycle ForwardAE=01, StallCount=1.
2. RegWrite_M=RegWrite_W=1, WriteReg_M=WriteReg_W=Rs_E=5 -> ForwardAE=10. Repeat with Rs_E=0 -> ForwardAE=00.
3. Branch_D with Rs_D=9 and RegWrite_E=1, WriteReg_E=9 -> 1 stall cycle. Next cycle RegWrite_M, WriteReg_M=9 -> ForwardAD=1, no stall.
4. MulDivStart_E, MulDivIsDiv_E=0, MUL_LAT=4, MFLO in ID -> MulDivBusy high 4 cycles; StallD high from the start cycle through the last BUSY cycle; MulDivDone pulses once; StallCount=5.
5. DIV start; assert rst_n=0 on the 10th BUSY cycle -> next edge: state IDLE, MulDivBusy=0, StallCount=0, FlushE=1 while rst_n low.
6. Force 2^32 stall cycles (preload via hierarchical deposit to 32'hFFFF_FFFE) -> StallCount sticks at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control blocks: forwarding mux
// encodings, the multiply/divide sequencer states and a register-match helper.
package mips_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } md_state_t;

    // $0 is hardwired to zero, so a write to it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Multiply/divide occupancy sequencer: tracks how long the multi-cycle unit
// stays busy and pulses done for one cycle when HI/LO become valid.
module muldiv_seq
    import mips_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic is_div,
    output logic busy,
    output logic done
);

    md_state_t          state;
    md_state_t          state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [CNT_W-1:0]   cnt_load;

    assign cnt_load = is_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // A start arriving while BUSY is ignored; ID is held by the stall logic.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = BUSY;
                    cnt_next   = cnt_load;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                if (start) begin
                    state_next = BUSY;
                    cnt_next   = cnt_load;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign busy = (state == BUSY);
    assign done = (state == DONE);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage MIPS core: stall/flush control,
// ID and EX forwarding selects, mul/div sequencing and a stall-cycle counter.
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  Rs_D,
    input  logic [4:0]  Rt_D,
    input  logic [4:0]  Rs_E,
    input  logic [4:0]  Rt_E,
    input  logic [4:0]  WriteReg_E,
    input  logic [4:0]  WriteReg_M,
    input  logic [4:0]  WriteReg_W,
    input  logic        RegWrite_E,
    input  logic        RegWrite_M,
    input  logic        RegWrite_W,
    input  logic        MemtoReg_E,
    input  logic        MemtoReg_M,
    input  logic        Branch_D,
    input  logic        MulDivStart_E,
    input  logic        MulDivIsDiv_E,
    input  logic        MulDivUse_D,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushE,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        ForwardAD,
    output logic        ForwardBD,
    output logic        MulDivBusy,
    output logic        MulDivDone,
    output logic [31:0] StallCount
);

    logic        lw_stall;
    logic        br_stall;
    logic        md_stall;
    logic        stall;
    logic        md_busy;
    logic        md_done;
    logic [31:0] stall_count;

    muldiv_seq #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (CNT_W)
    ) u_muldiv_seq (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (MulDivStart_E),
        .is_div (MulDivIsDiv_E),
        .busy   (md_busy),
        .done   (md_done)
    );

    // MEM is the younger producer, so it takes priority over WB.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (RegWrite_M && reg_match(WriteReg_M, src)) begin
            return FWD_MEM;
        end else if (RegWrite_W && reg_match(WriteReg_W, src)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

    always_comb begin
        lw_stall = MemtoReg_E & (reg_match(Rt_E, Rs_D) | reg_match(Rt_E, Rt_D));
        br_stall = Branch_D &
                   ((RegWrite_E & (reg_match(WriteReg_E, Rs_D) | reg_match(WriteReg_E, Rt_D))) |
                    (MemtoReg_M & (reg_match(WriteReg_M, Rs_D) | reg_match(WriteReg_M, Rt_D))));
        md_stall = MulDivUse_D & (md_busy | MulDivStart_E);
        stall    = lw_stall | br_stall | md_stall;
    end

    // While in reset the ID/EX register is held flushed and everything else is quiet.
    always_comb begin
        StallF     = 1'b0;
        StallD     = 1'b0;
        FlushE     = 1'b1;
        ForwardAE  = FWD_RF;
        ForwardBE  = FWD_RF;
        ForwardAD  = 1'b0;
        ForwardBD  = 1'b0;
        MulDivBusy = 1'b0;
        MulDivDone = 1'b0;
        if (rst_n) begin
            StallF     = stall;
            StallD     = stall;
            FlushE     = stall;
            ForwardAE  = fwd_sel(Rs_E);
            ForwardBE  = fwd_sel(Rt_E);
            ForwardAD  = RegWrite_M & reg_match(WriteReg_M, Rs_D);
            ForwardBD  = RegWrite_M & reg_match(WriteReg_M, Rt_D);
            MulDivBusy = md_busy;
            MulDivDone = md_done;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall && (stall_count != 32'hFFFF_FFFF)) begin
            stall_count <= stall_count + 32'd1;
        end
    end

    assign StallCount = stall_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// traffic checked against a cycle-level behavioural model.
module tb_hazard_ctrl;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 32;
    localparam int CNT_W   = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  Rs_D, Rt_D, Rs_E, Rt_E;
    logic [4:0]  WriteReg_E, WriteReg_M, WriteReg_W;
    logic        RegWrite_E, RegWrite_M, RegWrite_W;
    logic        MemtoReg_E, MemtoReg_M, Branch_D;
    logic        MulDivStart_E, MulDivIsDiv_E, MulDivUse_D;
    logic        StallF, StallD, FlushE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        ForwardAD, ForwardBD;
    logic        MulDivBusy, MulDivDone;
    logic [31:0] StallCount;

    int total = 0;
    int bad   = 0;

    // Model: cycles of occupancy remaining, pending done pulse, stall total.
    int              m_left  = 0;
    bit              m_done  = 1'b0;
    longint unsigned m_count = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .Rs_D          (Rs_D),
        .Rt_D          (Rt_D),
        .Rs_E          (Rs_E),
        .Rt_E          (Rt_E),
        .WriteReg_E    (WriteReg_E),
        .WriteReg_M    (WriteReg_M),
        .WriteReg_W    (WriteReg_W),
        .RegWrite_E    (RegWrite_E),
        .RegWrite_M    (RegWrite_M),
        .RegWrite_W    (RegWrite_W),
        .MemtoReg_E    (MemtoReg_E),
        .MemtoReg_M    (MemtoReg_M),
        .Branch_D      (Branch_D),
        .MulDivStart_E (MulDivStart_E),
        .MulDivIsDiv_E (MulDivIsDiv_E),
        .MulDivUse_D   (MulDivUse_D),
        .StallF        (StallF),
        .StallD        (StallD),
        .FlushE        (FlushE),
        .ForwardAE     (ForwardAE),
        .ForwardBE     (ForwardBE),
        .ForwardAD     (ForwardAD),
        .ForwardBD     (ForwardBD),
        .MulDivBusy    (MulDivBusy),
        .MulDivDone    (MulDivDone),
        .StallCount    (StallCount)
    );

    function automatic logic [1:0] exp_fwd_e(input logic [4:0] src);
        if (!rst_n || src == 5'd0) return 2'b00;
        if (RegWrite_M && WriteReg_M == src) return 2'b10;
        if (RegWrite_W && WriteReg_W == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic exp_fwd_d(input logic [4:0] src);
        return rst_n && src != 5'd0 && RegWrite_M && WriteReg_M == src;
    endfunction

    function automatic bit hits_id(input logic [4:0] dst);
        return dst != 5'd0 && (dst == Rs_D || dst == Rt_D);
    endfunction

    function automatic logic exp_stall();
        bit lw, br, md;
        if (!rst_n) return 1'b0;
        lw = MemtoReg_E && hits_id(Rt_E);
        br = Branch_D && ((RegWrite_E && hits_id(WriteReg_E)) || (MemtoReg_M && hits_id(WriteReg_M)));
        md = MulDivUse_D && (m_left > 0 || MulDivStart_E);
        return lw || br || md;
    endfunction

    task automatic clear_inputs();
        {Rs_D, Rt_D, Rs_E, Rt_E} = '0;
        {WriteReg_E, WriteReg_M, WriteReg_W} = '0;
        {RegWrite_E, RegWrite_M, RegWrite_W} = '0;
        {MemtoReg_E, MemtoReg_M, Branch_D} = '0;
        {MulDivStart_E, MulDivIsDiv_E, MulDivUse_D} = '0;
    endtask

    // Advance one clock, updating the model from the inputs seen before the edge.
    task automatic tick();
        bit s, st, dv, r;
        s  = exp_stall();
        st = MulDivStart_E;
        dv = MulDivIsDiv_E;
        r  = rst_n;
        @(posedge clk);
        if (!r) begin
            m_left  = 0;
            m_done  = 1'b0;
            m_count = 0;
        end else begin
            if (s && m_count < 64'hFFFF_FFFF) m_count++;
            if (m_left > 0) begin
                m_left--;
                m_done = (m_left == 0);
            end else if (st) begin
                m_left = dv ? DIV_LAT : MUL_LAT;
                m_done = 1'b0;
            end else begin
                m_done = 1'b0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        MemtoReg_E = 1'b1; Rt_E = 5'd3; Rs_D = 5'd3;
        RegWrite_M = 1'b1; WriteReg_M = 5'd4; Rs_E = 5'd4;
        #1;
        total++; if (FlushE !== 1'b1) begin bad++; $display("[TB] FAIL reset_flush got=%b exp=1", FlushE); end
        total++; if (StallD !== 1'b0) begin bad++; $display("[TB] FAIL reset_stalld got=%b exp=0", StallD); end
        total++; if (StallF !== 1'b0) begin bad++; $display("[TB] FAIL reset_stallf got=%b exp=0", StallF); end
        total++; if (ForwardAE !== 2'b00) begin bad++; $display("[TB] FAIL reset_fwdae got=%b exp=00", ForwardAE); end
        tick();
        rst_n = 1'b1;
        clear_inputs();
        #1;
        total++; if (StallCount !== 32'd0) begin bad++; $display("[TB] FAIL reset_count got=%0d exp=0", StallCount); end
        total++; if (MulDivBusy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", MulDivBusy); end
        total++; if (FlushE !== 1'b0) begin bad++; $display("[TB] FAIL reset_release_flush got=%b exp=0", FlushE); end
    endtask

    task automatic test_lwstall();
        do_reset();
        MemtoReg_E = 1'b1; Rt_E = 5'd8; Rs_D = 5'd8; Rt_D = 5'd2;
        #1;
        total++; if ({StallF, StallD, FlushE} !== 3'b111) begin bad++; $display("[TB] FAIL lw_stall got=%b exp=111", {StallF, StallD, FlushE}); end
        tick();
        clear_inputs();
        Rs_E = 5'd8; RegWrite_W = 1'b1; WriteReg_W = 5'd8; Rs_D = 5'd8;
        #1;
        total++; if (ForwardAE !== 2'b01) begin bad++; $display("[TB] FAIL lw_fwd got=%b exp=01", ForwardAE); end
        total++; if (StallD !== 1'b0) begin bad++; $display("[TB] FAIL lw_nostall got=%b exp=0", StallD); end
        total++; if (StallCount !== 32'd1) begin bad++; $display("[TB] FAIL lw_count got=%0d exp=1", StallCount); end
        clear_inputs();
        MemtoReg_E = 1'b1; Rt_E = 5'd0; Rs_D = 5'd0;
        #1;
        total++; if (StallD !== 1'b0) begin bad++; $display("[TB] FAIL lw_r0 got=%b exp=0", StallD); end
        tick();
    endtask

    task automatic test_forward();
        clear_inputs();
        RegWrite_M = 1'b1; RegWrite_W = 1'b1; WriteReg_M = 5'd5; WriteReg_W = 5'd5; Rs_E = 5'd5;
        #1;
        total++; if (ForwardAE !== 2'b10) begin bad++; $display("[TB] FAIL fwd_mem_wins got=%b exp=10", ForwardAE); end
        WriteReg_M = 5'd0; WriteReg_W = 5'd0; Rs_E = 5'd0;
        #1;
        total++; if (ForwardAE !== 2'b00) begin bad++; $display("[TB] FAIL fwd_r0 got=%b exp=00", ForwardAE); end
        WriteReg_M = 5'd6; WriteReg_W = 5'd5; Rs_E = 5'd5; Rt_E = 5'd6;
        #1;
        total++; if (ForwardAE !== 2'b01) begin bad++; $display("[TB] FAIL fwd_wb got=%b exp=01", ForwardAE); end
        total++; if (ForwardBE !== 2'b10) begin bad++; $display("[TB] FAIL fwd_be_mem got=%b exp=10", ForwardBE); end
        RegWrite_M = 1'b0;
        #1;
        total++; if (ForwardBE !== 2'b00) begin bad++; $display("[TB] FAIL fwd_be_nowrite got=%b exp=00", ForwardBE); end
        tick();
    endtask

    task automatic test_branch();
        do_reset();
        Branch_D = 1'b1; Rs_D = 5'd9; Rt_D = 5'd1; RegWrite_E = 1'b1; WriteReg_E = 5'd9;
        #1;
        total++; if (StallD !== 1'b1) begin bad++; $display("[TB] FAIL br_stall got=%b exp=1", StallD); end
        tick();
        RegWrite_E = 1'b0; WriteReg_E = 5'd0; RegWrite_M = 1'b1; WriteReg_M = 5'd9;
        #1;
        total++; if (ForwardAD !== 1'b1) begin bad++; $display("[TB] FAIL br_fwdad got=%b exp=1", ForwardAD); end
        total++; if (ForwardBD !== 1'b0) begin bad++; $display("[TB] FAIL br_fwdbd got=%b exp=0", ForwardBD); end
        total++; if (StallD !== 1'b0) begin bad++; $display("[TB] FAIL br_nostall got=%b exp=0", StallD); end
        MemtoReg_M = 1'b1; WriteReg_M = 5'd1;
        #1;
        total++; if (StallD !== 1'b1) begin bad++; $display("[TB] FAIL br_load_mem got=%b exp=1", StallD); end
        tick();
        total++; if (StallCount !== 32'd2) begin bad++; $display("[TB] FAIL br_count got=%0d exp=2", StallCount); end
    endtask

    task automatic test_mul();
        int done_pulses = 0;
        do_reset();
        MulDivStart_E = 1'b1; MulDivIsDiv_E = 1'b0; MulDivUse_D = 1'b1;
        #1;
        total++; if (StallD !== 1'b1) begin bad++; $display("[TB] FAIL mul_start_stall got=%b exp=1", StallD); end
        tick();
        MulDivStart_E = 1'b0;
        for (int i = 0; i < MUL_LAT; i++) begin
            #1;
            total++; if ({MulDivBusy, StallD, MulDivDone} !== 3'b110) begin
                bad++; $display("[TB] FAIL mul_busy cyc=%0d got=%b exp=110", i, {MulDivBusy, StallD, MulDivDone});
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            #1;
            if (MulDivDone === 1'b1) done_pulses++;
            total++; if (MulDivBusy !== 1'b0 || StallD !== 1'b0) begin
                bad++; $display("[TB] FAIL mul_after cyc=%0d busy=%b stalld=%b exp=0,0", i, MulDivBusy, StallD);
            end
            tick();
        end
        total++; if (done_pulses != 1) begin bad++; $display("[TB] FAIL mul_done_pulses got=%0d exp=1", done_pulses); end
        total++; if (StallCount !== 32'd5) begin bad++; $display("[TB] FAIL mul_count got=%0d exp=5", StallCount); end
    endtask

    task automatic test_div_reset();
        do_reset();
        MulDivStart_E = 1'b1; MulDivIsDiv_E = 1'b1; MulDivUse_D = 1'b1;
        tick();
        MulDivStart_E = 1'b0;
        for (int i = 1; i < 10; i++) begin
            #1;
            total++; if (MulDivBusy !== 1'b1) begin bad++; $display("[TB] FAIL div_busy cyc=%0d got=%b exp=1", i, MulDivBusy); end
            tick();
        end
        total++; if (StallCount !== 32'd10) begin bad++; $display("[TB] FAIL div_count got=%0d exp=10", StallCount); end
        rst_n = 1'b0;
        #1;
        total++; if (FlushE !== 1'b1 || MulDivBusy !== 1'b0 || StallD !== 1'b0) begin
            bad++; $display("[TB] FAIL div_rst_forced flush=%b busy=%b stalld=%b exp=1,0,0", FlushE, MulDivBusy, StallD);
        end
        tick();
        total++; if (StallCount !== 32'd0) begin bad++; $display("[TB] FAIL div_rst_count got=%0d exp=0", StallCount); end
        total++; if (FlushE !== 1'b1) begin bad++; $display("[TB] FAIL div_rst_flush got=%b exp=1", FlushE); end
        rst_n = 1'b1;
        MulDivUse_D = 1'b0;
        #1;
        total++; if (MulDivBusy !== 1'b0 || MulDivDone !== 1'b0) begin
            bad++; $display("[TB] FAIL div_rst_idle busy=%b done=%b exp=0,0", MulDivBusy, MulDivDone);
        end
        tick();
    endtask

    task automatic test_saturate();
        do_reset();
        dut.stall_count = 32'hFFFF_FFFE;
        m_count = 64'hFFFF_FFFE;
        MemtoReg_E = 1'b1; Rt_E = 5'd7; Rs_D = 5'd7;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            total++; if (StallCount !== 32'hFFFF_FFFF) begin
                bad++; $display("[TB] FAIL sat_count cyc=%0d got=%h exp=ffffffff", i, StallCount);
            end
        end
        clear_inputs();
    endtask

    task automatic test_random();
        logic       es;
        logic [1:0] eae, ebe;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst_n         = ($urandom_range(0, 99) != 0);
            Rs_D          = 5'($urandom_range(0, 3));
            Rt_D          = 5'($urandom_range(0, 3));
            Rs_E          = 5'($urandom_range(0, 3));
            Rt_E          = 5'($urandom_range(0, 3));
            WriteReg_E    = 5'($urandom_range(0, 3));
            WriteReg_M    = 5'($urandom_range(0, 3));
            WriteReg_W    = 5'($urandom_range(0, 3));
            RegWrite_E    = 1'($urandom);
            RegWrite_M    = 1'($urandom);
            RegWrite_W    = 1'($urandom);
            MemtoReg_E    = ($urandom_range(0, 3) == 0);
            MemtoReg_M    = ($urandom_range(0, 3) == 0);
            Branch_D      = ($urandom_range(0, 3) == 0);
            MulDivUse_D   = ($urandom_range(0, 3) == 0);
            MulDivIsDiv_E = ($urandom_range(0, 3) == 0);
            MulDivStart_E = (m_left == 0) && ($urandom_range(0, 7) == 0);
            #1;
            es  = exp_stall();
            eae = exp_fwd_e(Rs_E);
            ebe = exp_fwd_e(Rt_E);
            total++; if (StallD !== es || StallF !== es) begin
                bad++; $display("[TB] FAIL rand_stall cyc=%0d got=%b%b exp=%b", c, StallF, StallD, es);
            end
            total++; if (FlushE !== (es | !rst_n)) begin
                bad++; $display("[TB] FAIL rand_flush cyc=%0d got=%b exp=%b", c, FlushE, es | !rst_n);
            end
            total++; if (ForwardAE !== eae || ForwardBE !== ebe) begin
                bad++; $display("[TB] FAIL rand_fwd_e cyc=%0d got=%b/%b exp=%b/%b", c, ForwardAE, ForwardBE, eae, ebe);
            end
            total++; if (ForwardAD !== exp_fwd_d(Rs_D) || ForwardBD !== exp_fwd_d(Rt_D)) begin
                bad++; $display("[TB] FAIL rand_fwd_d cyc=%0d got=%b/%b exp=%b/%b", c, ForwardAD, ForwardBD, exp_fwd_d(Rs_D), exp_fwd_d(Rt_D));
            end
            total++; if (MulDivBusy !== (rst_n && m_left > 0) || MulDivDone !== (rst_n && m_done)) begin
                bad++; $display("[TB] FAIL rand_muldiv cyc=%0d got=%b/%b exp=%b/%b", c, MulDivBusy, MulDivDone, rst_n && m_left > 0, rst_n && m_done);
            end
            total++; if (StallCount !== m_count[31:0]) begin
                bad++; $display("[TB] FAIL rand_count cyc=%0d got=%0d exp=%0d", c, StallCount, m_count[31:0]);
            end
            tick();
        end
        rst_n = 1'b1;
        clear_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        @(posedge clk);
        #1;
        test_reset();
        test_lwstall();
        test_forward();
        test_branch();
        test_mul();
        test_div_reset();
        test_saturate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
